// File: rtl/next_pc_unit.sv
// Next-PC selection: sequential pc+4, prioritised redirects (exception > branch > jump),
// and a HOLD state that keeps a redirect alive across stalls. Optional macro: NEXT_PC_EXC_EN.
module next_pc_unit #(
  parameter int                 ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0,
  parameter logic [31:0]        EXC_VEC  = 32'h0000_0080
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_target,
`ifdef NEXT_PC_EXC_EN
  input  logic              exc_req,
`endif
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic              flush,
  output logic              pending
);

  // state | meaning
  // RUN   | normal fetch; redirects load immediately unless stalled
  // HOLD  | stalled with a redirect parked in pend_target/pend_class
  typedef enum logic {RUN, HOLD} state_t;

  localparam logic [ADDR_W-1:0] EXC_ADDR = EXC_VEC[ADDR_W-1:0];

  state_t            state;
  logic [ADDR_W-1:0] pend_target;
  logic [1:0]        pend_class;

  logic              exc;
  logic              req_valid;
  logic [1:0]        req_class;
  logic [ADDR_W-1:0] req_raw;
  logic [ADDR_W-1:0] req_target;
  logic              take_new;
  logic [ADDR_W-1:0] sel_target;

`ifdef NEXT_PC_EXC_EN
  assign exc = exc_req;
`else
  assign exc = 1'b0;
`endif

  assign pc_plus4 = pc + ADDR_W'(4);

  always_comb begin
    req_valid = exc | br_taken | jump;
    req_class = 2'd0;
    req_raw   = jump_target;
    if (exc) begin
      req_class = 2'd2;
      req_raw   = EXC_ADDR;
    end else if (br_taken) begin
      req_class = 2'd1;
      req_raw   = br_target;
    end
  end

  // Every loaded target is word aligned.
  assign req_target = {req_raw[ADDR_W-1:2], 2'b00};

  // A new request in HOLD only displaces the parked one if it is at least as urgent.
  assign take_new   = req_valid && (req_class >= pend_class);
  assign sel_target = take_new ? req_target : pend_target;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= {RESET_PC[ADDR_W-1:2], 2'b00};
      flush       <= 1'b0;
      pending     <= 1'b0;
      state       <= RUN;
      pend_target <= '0;
      pend_class  <= 2'd0;
    end else begin
      flush <= 1'b0;
      case (state)
        RUN: begin
          if (!stall) begin
            if (req_valid) begin
              pc    <= req_target;
              flush <= 1'b1;
            end else begin
              pc <= pc_plus4;
            end
          end else if (req_valid) begin
            pend_target <= req_target;
            pend_class  <= req_class;
            pending     <= 1'b1;
            state       <= HOLD;
          end
        end
        HOLD: begin
          if (stall) begin
            if (take_new) begin
              pend_target <= req_target;
              pend_class  <= req_class;
            end
          end else begin
            pc          <= sel_target;
            flush       <= 1'b1;
            pending     <= 1'b0;
            state       <= RUN;
            pend_target <= '0;
            pend_class  <= 2'd0;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: doc/next_pc_unit.md
NEXT_PC_UNIT -- requirements
Module: next_pc_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: PC and target width, legal range 8 to 32.
REQ-002 SHALL have parameter RESET_PC, default 0: PC value loaded on reset.
REQ-003 SHALL have parameter EXC_VEC, default 32'h0000_0080: exception entry address, truncated to ADDR_W bits.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port stall, input, 1 bit: freezes the PC.
REQ-007 SHALL have port br_taken, input, 1 bit: branch redirect request.
REQ-008 SHALL have port br_target, input, ADDR_W bits: branch target.
REQ-009 SHALL have port jump, input, 1 bit: jump redirect request.
REQ-010 SHALL have port jump_target, input, ADDR_W bits: jump target.
REQ-011 SHALL have port exc_req, input, 1 bit: exception redirect request; present only with NEXT_PC_EXC_EN.
REQ-012 SHALL have port pc, output, ADDR_W bits: registered fetch PC.
REQ-013 SHALL have port pc_plus4, output, ADDR_W bits: combinational pc+4.
REQ-014 SHALL have port flush, output, 1 bit: one-cycle pulse marking the PC load of a redirect target.
REQ-015 SHALL have port pending, output, 1 bit: high while a redirect is held in state HOLD.

Function
REQ-016 SHALL give redirect priority exception (2) > branch (1) > jump (0); sequential update applies only when no redirect is requested.
REQ-017 SHALL force bits [1:0] of every loaded target to 0.
REQ-018 SHALL compute pc_plus4 as pc+4 modulo 2^ADDR_W, wrapping to 0.
REQ-019 SHALL implement two states, RUN and HOLD.
REQ-020 In RUN with stall=0, SHALL load the highest-priority requested target with flush=1 the next cycle; with no request, SHALL load pc_plus4 with flush=0.
REQ-021 In RUN with stall=1 and no request, SHALL hold pc and stay in RUN.
REQ-022 In RUN with stall=1 and a request, SHALL hold pc, store the target and its class in a pending register, and go to HOLD.
REQ-023 In HOLD, a new request SHALL replace the pending entry only if its class is >= the stored class; lower classes are dropped.
REQ-024 In HOLD with stall=0, SHALL load the surviving entry (same-cycle request if it qualifies under REQ-023, else stored) with flush=1, then return to RUN; pending SHALL be 0 from that load.
REQ-025 SHALL never load pc_plus4 while in HOLD, and SHALL never pulse flush while stall=1.
REQ-026 SHALL register flush with 1-cycle latency from the accepting edge; back-to-back redirects SHALL produce consecutive flush pulses.

Reset
REQ-027 On rst=1 at a clock edge, SHALL set pc=RESET_PC (low bits forced 0), flush=0, pending=0, state RUN, pending entry cleared.
REQ-028 Reset SHALL override stall and all requests in the same cycle; a redirect held in HOLD SHALL be discarded.

Configuration
REQ-029 With macro NEXT_PC_EXC_EN defined, SHALL provide exc_req and load EXC_VEC as the class-2 redirect.
REQ-030 Without NEXT_PC_EXC_EN, exc_req and class 2 SHALL not exist, and behaviour SHALL be identical to the defined build with exc_req tied 0.

Verification
REQ-031 Reset, then 3 idle cycles -> pc = 0, 4, 8, 12; flush=0 throughout.
REQ-032 pc=0x100, br_taken=1, br_target=0x203 -> next pc=0x200, flush=1 for one cycle, then pc=0x204.
REQ-033 stall=1 with jump=1, jump_target=0x400, then branch to 0x300 one cycle later, stall released after 3 cycles -> pending=1 during stall, pc frozen, then pc=0x300 with flush=1.
REQ-034 In HOLD with a stored branch, a jump arrives -> ignored, and the branch target is loaded on release.
REQ-035 pc=0xFFFF_FFFC, no request -> next pc=0x0000_0000; with NEXT_PC_EXC_EN, exc_req=1 together with br_taken=1 -> pc=0x80.
REQ-036 rst=1 asserted while pending=1 -> pc=RESET_PC, pending=0, no flush after release.
